branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_branch_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller: evaluates a captured branch, redirects fetch on
// a mispredict, and trains a table of 2-bit saturating predictors.
module branch_ctrl #(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic        res_branch,
    input  logic [2:0]  res_funct3,
    input  logic [31:0] res_a,
    input  logic [31:0] res_b,
    input  logic [31:0] res_pc,
    input  logic [31:0] res_imm,
    input  logic        res_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [15:0] mispredict_cnt
);
    localparam int IDX = $clog2(BHT_ENTRIES);

    typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

    state_t      state_q, state_d;
    logic        branch_q, branch_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imm_q, imm_d;
    logic        pred_q, pred_d;
    logic [15:0] cnt_q, cnt_d;

    logic [1:0]     bht_q [BHT_ENTRIES];
    logic           bht_we;
    logic [IDX-1:0] bht_widx;
    logic [1:0]     bht_wval;

    logic        valid_code;
    logic        taken;
    logic        mispredict;
    logic [31:0] target;

    // Branch condition evaluation on the captured operands
    always_comb begin
        valid_code = 1'b0;
        taken      = 1'b0;
        case (funct3_q)
            3'b000: begin valid_code = 1'b1; taken = (a_q == b_q); end
            3'b001: begin valid_code = 1'b1; taken = (a_q != b_q); end
            3'b100: begin valid_code = 1'b1; taken = ($signed(a_q) <  $signed(b_q)); end
            3'b101: begin valid_code = 1'b1; taken = ($signed(a_q) >= $signed(b_q)); end
            3'b110: begin valid_code = 1'b1; taken = (a_q <  b_q); end
            3'b111: begin valid_code = 1'b1; taken = (a_q >= b_q); end
            default: begin valid_code = 1'b0; taken = 1'b0; end
        endcase
        if (!branch_q) begin
            taken = 1'b0;
        end
        target     = taken ? (pc_q + imm_q) : (pc_q + 32'd4);
        mispredict = (taken != pred_q);
    end

    always_comb begin
        state_d  = state_q;
        branch_d = branch_q;
        funct3_d = funct3_q;
        a_d      = a_q;
        b_d      = b_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        pred_d   = pred_q;
        cnt_d    = cnt_q;
        bht_we   = 1'b0;
        bht_widx = pc_q[IDX+1:2];
        bht_wval = bht_q[pc_q[IDX+1:2]];
        case (state_q)
            IDLE: begin
                if (res_valid) begin
                    branch_d = res_branch;
                    funct3_d = res_funct3;
                    a_d      = res_a;
                    b_d      = res_b;
                    pc_d     = res_pc;
                    imm_d    = res_imm;
                    pred_d   = res_pred_taken;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                if (branch_q && valid_code) begin
                    bht_we = 1'b1;
                    if (taken && bht_wval != 2'b11) begin
                        bht_wval = bht_wval + 2'b01;
                    end else if (!taken && bht_wval != 2'b00) begin
                        bht_wval = bht_wval - 2'b01;
                    end
                end
                if (mispredict) begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    state_d = REDIRECT;
                end else begin
                    state_d = IDLE;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            branch_q <= 1'b0;
            funct3_q <= 3'b000;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            pc_q     <= 32'd0;
            imm_q    <= 32'd0;
            pred_q   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            branch_q <= branch_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            pred_q   <= pred_d;
            cnt_q    <= cnt_d;
        end
    end

    // Counters reset to weakly not-taken; lookups see the pre-write value
    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            always_ff @(posedge clk) begin
                if (rst) begin
                    bht_q[gi] <= 2'b01;
                end else if (bht_we && bht_widx == IDX'(gi)) begin
                    bht_q[gi] <= bht_wval;
                end
            end
        end
    endgenerate

    assign pred_taken     = bht_q[pred_pc[IDX+1:2]][1];
    assign res_ready      = (state_q == IDLE);
    assign redirect_valid = (state_q == REDIRECT);
    assign flush          = redirect_valid;
    assign redirect_pc    = redirect_valid ? target : 32'd0;
    assign mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: redirects are checked by a scoreboard monitor,
// latency, counters and predictor bits by the stimulus process.
module tb_branch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic        res_ready;
    logic        res_branch;
    logic [2:0]  res_funct3;
    logic [31:0] res_a, res_b, res_pc, res_imm;
    logic        res_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [15:0] mispredict_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    branch_ctrl #(.BHT_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_ready(res_ready), .res_branch(res_branch),
        .res_funct3(res_funct3), .res_a(res_a), .res_b(res_b), .res_pc(res_pc),
        .res_imm(res_imm), .res_pred_taken(res_pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest expected target
    always @(negedge clk) begin
        if (redirect_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_redirect: got pc 0x%08h expected no redirect", redirect_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (redirect_pc !== e || flush !== 1'b1) begin
                    failures++;
                    $display("FAIL redirect: got pc 0x%08h flush %0b expected pc 0x%08h flush 1",
                             redirect_pc, flush, e);
                end else begin
                    $display("redirect pc=0x%08h ok", redirect_pc);
                end
            end
        end
    end

    task automatic send(input logic br, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                        input logic pred, input logic exp_mis, input logic [31:0] exp_pc);
        @(negedge clk);
        checks++;
        if (res_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_issue: got %0b expected 1", res_ready);
        end
        res_branch = br; res_funct3 = f3; res_a = a; res_b = b;
        res_pc = pc; res_imm = imm; res_pred_taken = pred; res_valid = 1'b1;
        if (exp_mis) exp_q.push_back(exp_pc);
        @(posedge clk); #1;
        res_valid = 1'b0;
        res_a = 32'hDEAD_BEEF; res_b = 32'h1234_5678; res_pc = 32'h0; res_imm = 32'h0;
        @(posedge clk); #1;
        check("ready_n2", {31'd0, res_ready}, {31'd0, ~exp_mis});
        check("redirect_n2", {31'd0, redirect_valid}, {31'd0, exp_mis});
        if (exp_mis) begin
            @(posedge clk); #1;
            check("ready_n3", {31'd0, res_ready}, 32'd1);
            check("redirect_n3", {31'd0, redirect_valid}, 32'd0);
        end
        $display("txn br=%0b f3=%03b pc=0x%08h pred=%0b exp_mis=%0b cnt=%0d",
                 br, f3, pc, pred, exp_mis, mispredict_cnt);
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
        pred_pc = pc;
        #1;
        check(name, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; res_valid = 1'b0; res_branch = 1'b0; res_funct3 = 3'b000;
        res_a = 0; res_b = 0; res_pc = 0; res_imm = 0; res_pred_taken = 1'b0; pred_pc = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", {31'd0, res_ready}, 32'd1);
        check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_cnt", {16'd0, mispredict_cnt}, 32'd0);
        check_pred("rst_pred", 32'h100, 1'b0);

        // beq taken, predicted not-taken
        send(1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 0, 1, 32'h120);
        check("beq_cnt", {16'd0, mispredict_cnt}, 32'd1);
        check_pred("beq_bht0", 32'h100, 1'b1);
        // blt signed taken, bltu unsigned not taken
        send(1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 0, 32'h0);
        check("blt_cnt", {16'd0, mispredict_cnt}, 32'd1);
        send(1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, 1, 1, 32'h304);
        check("bltu_cnt", {16'd0, mispredict_cnt}, 32'd2);

        // Saturation at pc 0x40 from a fresh table
        do_reset();
        check("rst2_cnt", {16'd0, mispredict_cnt}, 32'd0);
        check_pred("sat_pre", 32'h40, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(1, 3'b000, 32'd7, 32'd7, 32'h40, 32'h80, 1, 0, 32'h0);
            check_pred("sat_taken", 32'h40, 1'b1);
        end
        send(1, 3'b000, 32'd7, 32'd8, 32'h40, 32'h80, 1, 1, 32'h44);
        check_pred("sat_dec1", 32'h40, 1'b1);
        send(1, 3'b000, 32'd7, 32'd8, 32'h40, 32'h80, 0, 0, 32'h0);
        check_pred("sat_dec2", 32'h40, 1'b0);
        check("sat_cnt", {16'd0, mispredict_cnt}, 32'd1);

        // Target wraps modulo 2^32
        send(1, 3'b000, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'd8, 0, 1, 32'h0000_0004);
        check_pred("wrap_bht15", 32'hFFFF_FFFC, 1'b1);
        check("wrap_cnt", {16'd0, mispredict_cnt}, 32'd2);

        // Non-branch and reserved funct3 leave the table alone
        send(0, 3'b000, 32'd9, 32'd9, 32'h3C, 32'h100, 1, 1, 32'h40);
        check_pred("nobr_bht15", 32'h3C, 1'b1);
        send(1, 3'b010, 32'd9, 32'd9, 32'h3C, 32'h100, 1, 1, 32'h40);
        check_pred("f010_bht15", 32'h3C, 1'b1);
        check("nobr_cnt", {16'd0, mispredict_cnt}, 32'd4);

        // bge / bgeu / bne
        send(1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h500, 32'h100, 0, 0, 32'h0);
        send(1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h600, 32'h100, 0, 1, 32'h700);
        send(1, 3'b001, 32'd3, 32'd4, 32'h8, 32'h40, 1, 0, 32'h0);
        check_pred("bne_bht2", 32'h8, 1'b1);
        check("misc_cnt", {16'd0, mispredict_cnt}, 32'd5);

        // Reset while a mispredicting branch is in EVAL
        @(negedge clk);
        res_branch = 1; res_funct3 = 3'b000; res_a = 1; res_b = 1;
        res_pc = 32'h10; res_imm = 32'h40; res_pred_taken = 0; res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_cnt", {16'd0, mispredict_cnt}, 32'd0);
        check("abort_ready", {31'd0, res_ready}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            check_pred("abort_pred", 32'(i) << 2, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_redirect: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
